// File: rtl/adc_readout_ctrl.sv
// Serial-ADC readout sequencer: periodic soc pulse, conversion wait, NBITS-clock SIPO shift gate, sample latch.
// All outputs registered; triggers arriving mid-conversion are dropped and flagged on overrun.
module adc_readout_ctrl #(
  parameter int NBITS     = 12,
  parameter int PERIOD    = 1000,
  parameter int SOC_WIDTH = 1,
  parameter int CONV_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NBITS-1:0] pdata_in,
  output logic             soc,
  output logic             si_en,
  output logic [NBITS-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic [15:0]      sample_cnt
);

  localparam int PCW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int MAX_PH0 = (SOC_WIDTH > CONV_WAIT) ? SOC_WIDTH : CONV_WAIT;
  localparam int MAX_PH  = (MAX_PH0 > NBITS) ? MAX_PH0 : NBITS;
  localparam int PHW     = $clog2(MAX_PH + 1);
  localparam int SOC_LD  = SOC_WIDTH - 1;
  localparam int WAIT_LD = (CONV_WAIT > 0) ? CONV_WAIT - 1 : 0;
  localparam int SHF_LD  = NBITS - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOC   = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    LATCH = 3'd4
  } state_t;

  state_t           state_q;
  logic [PHW-1:0]   phase_q;
  logic [PCW-1:0]   per_cnt_q, per_cnt_d;
  logic             soc_q, si_en_q, data_valid_q, busy_q, overrun_q;
  logic [NBITS-1:0] data_q;
  logic [15:0]      sample_cnt_q;
  logic             trigger;

  // Counter parks at 0 while disabled so the first enabled clock triggers.
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (!en) begin
      per_cnt_d = '0;
    end else if (per_cnt_q == PCW'(PERIOD - 1)) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + PCW'(1);
    end
  end

  assign trigger = en && (per_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      soc_q        <= 1'b0;
      si_en_q      <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      data_q       <= '0;
      sample_cnt_q <= '0;
    end else begin
      data_valid_q <= 1'b0;
      overrun_q    <= trigger && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q <= SOC;
            phase_q <= PHW'(SOC_LD);
            soc_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SOC: begin
          if (phase_q == '0) begin
            soc_q <= 1'b0;
            if (CONV_WAIT == 0) begin
              state_q <= SHIFT;
              phase_q <= PHW'(SHF_LD);
              si_en_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              phase_q <= PHW'(WAIT_LD);
            end
          end else begin
            phase_q <= phase_q - PHW'(1);
          end
        end
        WAIT: begin
          if (phase_q == '0) begin
            state_q <= SHIFT;
            phase_q <= PHW'(SHF_LD);
            si_en_q <= 1'b1;
          end else begin
            phase_q <= phase_q - PHW'(1);
          end
        end
        SHIFT: begin
          if (phase_q == '0) begin
            state_q <= LATCH;
            si_en_q <= 1'b0;
          end else begin
            phase_q <= phase_q - PHW'(1);
          end
        end
        LATCH: begin
          // SIPO holds the complete word during this clock.
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          data_q       <= pdata_in;
          data_valid_q <= 1'b1;
          sample_cnt_q <= sample_cnt_q + 16'd1;
        end
        default: begin
          state_q <= IDLE;
          soc_q   <= 1'b0;
          si_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign soc        = soc_q;
  assign si_en      = si_en_q;
  assign data_out   = data_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Scoreboard bench for adc_readout_ctrl: a serial ADC + SIPO model feeds dut_a, a PERIOD=10 instance exercises overrun and counter wrap.
`timescale 1ns/1ps
module tb_adc_readout_ctrl;
  localparam int NB = 12;

  logic          clk = 1'b0;
  logic          rst_n, en, en_b;
  logic [NB-1:0] sipo, pdata_b, adc_word;
  logic          soc, si_en, data_valid, busy, overrun;
  logic [NB-1:0] data_out;
  logic [15:0]   sample_cnt;
  logic          soc_b, si_en_b, data_valid_b, busy_b, overrun_b;
  logic [NB-1:0] data_out_b;
  logic [15:0]   sample_cnt_b;

  int n_tests = 0, n_fail = 0;
  logic [27:0] q_a[$], q_b[$];
  int n_exp_a = 0, rcv = 0, rcv_b = 0, n_ovr_b = 0;
  logic [15:0] exp_cnt = 16'd0;
  int cyc = 0, rise_cyc = 0, rise_epoch = 0, epoch = 0, soc_len = 0, si_len = 0;
  int n_soc_rise = 0, n_si = 0, hold_viol = 0, bit_idx = NB - 1;
  logic rise_valid = 1'b0, soc_prev = 1'b0, si_prev = 1'b0;
  logic [NB-1:0] last_dout = '0;

  always #5 clk = ~clk;

  adc_readout_ctrl #(.NBITS(NB), .PERIOD(40), .SOC_WIDTH(2), .CONV_WAIT(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pdata_in(sipo),
    .soc(soc), .si_en(si_en), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .overrun(overrun), .sample_cnt(sample_cnt));

  adc_readout_ctrl #(.NBITS(NB), .PERIOD(10), .SOC_WIDTH(2), .CONV_WAIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .pdata_in(pdata_b),
    .soc(soc_b), .si_en(si_en_b), .data_out(data_out_b), .data_valid(data_valid_b),
    .busy(busy_b), .overrun(overrun_b), .sample_cnt(sample_cnt_b));

  // Serial ADC presents MSB first; SIPO shifts only while si_en is high.
  always @(posedge clk) begin
    if (soc) begin
      bit_idx <= NB - 1;
    end else if (si_en) begin
      sipo    <= {sipo[NB-2:0], adc_word[bit_idx]};
      bit_idx <= bit_idx - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for dut_a: pulse timing relative to soc, scoreboard, data_out hold.
  always @(negedge clk) begin
    logic [27:0] e;
    cyc++;
    if (soc && !soc_prev) begin
      if (rise_valid && rise_epoch == epoch) check("soc_period", 32'(cyc - rise_cyc), 32'd40);
      rise_cyc = cyc; rise_epoch = epoch; rise_valid = 1'b1;
      soc_len = 0; si_len = 0; n_soc_rise++;
    end
    if (soc) soc_len++;
    if (si_en && !si_prev) check("si_en_start", 32'(cyc - rise_cyc), 32'd5);
    if (si_en) begin si_len++; n_si++; end
    if (data_valid) begin
      check("dv_latency", 32'(cyc - rise_cyc), 32'd18);
      check("soc_width", 32'(soc_len), 32'd2);
      check("si_en_width", 32'(si_len), 32'd12);
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_sample_a: data_out %h with empty queue", data_out);
      end else begin
        e = q_a.pop_front();
        check("data_out", 32'(data_out), 32'(e[27:16]));
        check("sample_cnt", 32'(sample_cnt), 32'(e[15:0]));
      end
      rcv++;
    end
    if (!rst_n || data_valid) last_dout = data_out;
    else if (data_out !== last_dout) hold_viol++;
    soc_prev = soc; si_prev = si_en;
  end

  always @(negedge clk) begin
    logic [27:0] e;
    if (overrun_b) n_ovr_b++;
    if (data_valid_b) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_sample_b: data_out %h with empty queue", data_out_b);
      end else begin
        e = q_b.pop_front();
        check("data_out_b", 32'(data_out_b), 32'(e[27:16]));
        check("sample_cnt_b", 32'(sample_cnt_b), 32'(e[15:0]));
      end
      rcv_b++;
    end
  end

  task automatic expect_a(input logic [NB-1:0] w);
    adc_word = w;
    exp_cnt  = exp_cnt + 16'd1;
    q_a.push_back({w, exp_cnt});
    n_exp_a++;
  endtask

  task automatic wait_a(input string name);
    int k = 0;
    while (rcv < n_exp_a && k < 200) begin @(negedge clk); k++; end
    check(name, 32'(rcv), 32'(n_exp_a));
  endtask

  task automatic wait_si(input string name);
    int k = 0;
    while (!si_en && k < 100) begin @(negedge clk); k++; end
    check(name, 32'(si_en), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_soc, base_si, k;
    rst_n = 1'b0; en = 1'b0; en_b = 1'b0; adc_word = '0; pdata_b = 12'h5A5; sipo = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({soc, si_en, data_valid, busy, overrun}), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    rst_n = 1'b1;
    base_soc = n_soc_rise; base_si = n_si;
    repeat (50) @(negedge clk);
    check("idle_soc", 32'(n_soc_rise - base_soc), 32'd0);
    check("idle_si_en", 32'(n_si - base_si), 32'd0);

    // Continuous conversions with a varied ADC word each time.
    expect_a(12'hA5C);
    en = 1'b1; epoch++;
    @(negedge clk);
    check("first_soc", 32'(soc), 32'd1);
    check("busy_soc", 32'(busy), 32'd1);
    wait_a("sample1_done");
    expect_a(12'h3C5); wait_a("sample2_done");
    expect_a(12'hFFF); wait_a("sample3_done");
    expect_a(12'h001); wait_a("sample4_done");

    // Disable during SHIFT: in-flight sample completes, then silence.
    expect_a(12'h9E1);
    wait_si("reach_shift");
    en = 1'b0; epoch++;
    wait_a("sample_after_en_drop");
    base_soc = n_soc_rise;
    repeat (100) @(negedge clk);
    check("no_soc_while_off", 32'(n_soc_rise - base_soc), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    expect_a(12'h1B7);
    en = 1'b1; epoch++;
    @(negedge clk);
    check("soc_after_reen", 32'(soc), 32'd1);
    en = 1'b0; epoch++;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("overrun_on_reen", 32'(overrun), 32'd1);
    @(negedge clk);
    check("overrun_one_clk", 32'(overrun), 32'd0);
    wait_a("sample_after_reen");
    en = 1'b0; epoch++;

    // Reset in the middle of a shift discards the partial sample.
    repeat (5) @(negedge clk);
    adc_word = 12'h6D2;
    en = 1'b1; epoch++;
    wait_si("reach_shift_rst");
    repeat (4) @(negedge clk);
    rst_n = 1'b0; en = 1'b0;
    #1;
    check("midrst_ctrl", 32'({soc, si_en, data_valid, busy, overrun}), 32'd0);
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_sample_cnt", 32'(sample_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    expect_a(12'h2F4);
    en = 1'b1; epoch++;
    wait_a("sample_after_rst");
    en = 1'b0; epoch++;

    // PERIOD=10 instance: every other trigger is dropped; counter wraps from 0xFFFF.
    @(negedge clk);
    force dut_b.sample_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_b.sample_cnt_q;
    @(negedge clk);
    check("preload_b", 32'(sample_cnt_b), 32'h0000FFFF);
    q_b.push_back({12'h5A5, 16'h0000});
    q_b.push_back({12'h5A5, 16'h0001});
    q_b.push_back({12'h5A5, 16'h0002});
    en_b = 1'b1;
    repeat (45) @(negedge clk);
    en_b = 1'b0;
    k = 0;
    while (rcv_b < 3 && k < 100) begin @(negedge clk); k++; end
    check("samples_b", 32'(rcv_b), 32'd3);
    check("overruns_b", 32'(n_ovr_b), 32'd2);

    check("queue_a_empty", 32'(q_a.size()), 32'd0);
    check("queue_b_empty", 32'(q_b.size()), 32'd0);
    check("data_out_hold", 32'(hold_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
